wr_fifo_burst_reader: RTL
=========================

# wr_fifo_burst_reader

Read-side drain engine for the frame write FIFO. Sits in the `rd_clk` domain between the FIFO read port and the DDR write master. It waits until the FIFO holds a full burst, then issues a fixed-length address request. It streams the burst out over a valid/ready write-data channel with a 2-entry skid buffer, and walks a frame-sized address window.

## Interface
Parameters:
- `c_DATA_WIDTH`, 32, FIFO read data / write beat width; must be a power of 2, ≥8.
- `c_LEVEL_WIDTH`, 11, width of FIFO read water level (`c_RD_DEPTH_WIDTH+1`).
- `c_ADDR_WIDTH`, 28, byte address width.
- `c_BURST_LEN`, 16, beats per burst; 2..256, ≤ FIFO depth.

Ports (one clock, `rd_clk`; reset `rd_rst` is asynchronous, active-high):
- `rd_clk` in 1, clock.
- `rd_rst` in 1, async active-high reset.
- `enable` in 1, run request; sampled only in IDLE and at burst boundaries.
- `cfg_base_addr` in `c_ADDR_WIDTH`, frame base byte address; latched on frame start.
- `cfg_frame_beats` in `c_ADDR_WIDTH`, beats per frame; nonzero multiple of `c_BURST_LEN`; latched on frame start.
- `fifo_rd_en` out 1, FIFO read enable; data is valid on `fifo_rd_data` the next cycle.
- `fifo_rd_data` in `c_DATA_WIDTH`, FIFO read data.
- `fifo_rd_empty` in 1, FIFO empty flag.
- `fifo_rd_water_level` in `c_LEVEL_WIDTH`, FIFO occupancy in read words.
- `aw_addr` out `c_ADDR_WIDTH`, burst start byte address.
- `aw_len` out 8, constant `c_BURST_LEN-1`.
- `aw_valid` out 1, address request.
- `aw_ready` in 1, address accept.
- `w_data` out `c_DATA_WIDTH`, write beat data.
- `w_valid` out 1, beat valid.
- `w_ready` in 1, beat accept.
- `w_last` out 1, final beat of the burst.
- `busy` out 1, high in any state other than IDLE.
- `frame_done` out 1, one-cycle pulse after the last beat of a frame.

## Operation
- FSM states: IDLE, WAIT_LEVEL, ADDR, DATA.
- IDLE:
  - When `enable`=1: latch base into `addr` and frame_beats into `remaining`, then go to WAIT_LEVEL.
- WAIT_LEVEL:
  - When `fifo_rd_water_level >= c_BURST_LEN`, go to ADDR. `aw_valid` is registered high on entry.
- ADDR:
  - Hold `aw_valid`/`aw_addr` stable until `aw_ready`, then go to DATA.
  - Prefetch begins here: FIFO reads may start in the ADDR state.
- DATA:
  - `w_valid` is asserted only in DATA while the skid buffer is non-empty.
  - A beat transfers on `w_valid & w_ready`. `w_last` is high on beat index `c_BURST_LEN-1`.
- Read issue rule:
  - `fifo_rd_en = (ADDR|DATA) & reads_left>0 & !fifo_rd_empty & (skid_count + inflight - pop) < 2`.
  - `inflight` is the previous cycle's `fifo_rd_en`.
  - Never issue more than `c_BURST_LEN` reads per burst.
- Skid buffer:
  - 2 entries. A write (FIFO return) and a pop may occur in the same cycle; count is unchanged in that case.
  - Must never overflow. Data order is strictly preserved.
- On the last beat accepted:
  - `addr += c_BURST_LEN*c_DATA_WIDTH/8`, wrapping modulo 2^`c_ADDR_WIDTH`.
  - `remaining -= c_BURST_LEN`.
- After the last beat, transition depends on `remaining` and `enable`:
  - `remaining`≠0 & `enable`: go to WAIT_LEVEL.
  - `remaining`==0: pulse `frame_done`. If `enable`, re-latch cfg and go to WAIT_LEVEL (continuous frames); else go to IDLE.
  - `enable`=0 with `remaining`≠0: go to IDLE and abandon the frame. The next enable restarts at `cfg_base_addr`.
- `enable` deasserted mid-burst: the current burst always completes (address and all beats).
- `fifo_rd_empty` while a read is owed: stall reads with no error. This is legal only if an external writer reset emptied the FIFO.

## Timing
- Reset values:
  - `fifo_rd_en`, `aw_valid`, `w_valid`, `w_last`, `busy`, `frame_done` = 0.
  - `aw_addr` = 0, `w_data` = 0.
  - State = IDLE, skid buffer empty.
  - `aw_len` is constant.
- Latency:
  - `enable` to `busy`: 1 cycle.
  - Level satisfied to `aw_valid`: 1 cycle.
  - Earliest `w_valid`: the cycle after the `aw_valid & aw_ready` handshake.
- Throughput: with `w_ready` held high, one beat per cycle with no bubbles after the first beat.
- `w_data`/`w_valid`/`w_last` stay stable while `w_valid & !w_ready`.
- Back-to-back bursts: `aw_valid` for burst N+1 rises no earlier than 1 cycle after burst N's `w_last` handshake.
- `frame_done` is asserted in the cycle after the final `w_last` handshake.
- `rd_rst` asserted mid-burst: all outputs go immediately to reset values; no partial burst completion.

## Test plan
- Basic frame:
  - Stimulus: base=0x100, frame_beats=32, `c_BURST_LEN`=16, FIFO preloaded 32 words 0..31, `aw_ready`/`w_ready`=1.
  - Response: two bursts at 0x100 and 0x140, `w_data` 0..31 in order, `w_last` on beats 15 and 31, one `frame_done`.
- Level gating:
  - Stimulus: FIFO level 15.
  - Response: no `aw_valid`. The 16th write raises level to 16, then `aw_valid` follows 1 cycle later.
- Backpressure:
  - Stimulus: random `w_ready` (50%) and `aw_ready` delayed 5 cycles.
  - Response: data order intact, no FIFO over-read (exactly 16 `fifo_rd_en` per burst), `aw_valid`/`aw_addr` stable until accepted.
- Address wrap:
  - Stimulus: `c_ADDR_WIDTH`=8, base=0xC0, frame_beats=48.
  - Response: addresses 0xC0, 0x00, 0x40.
- Enable drop:
  - Stimulus: enable→0 during beat 5 of burst 1 of a 64-beat frame.
  - Response: burst completes with 16 beats and `w_last`; FSM goes to IDLE; no `frame_done`. Re-enable restarts at base.
- Reset mid-burst:
  - Stimulus: `rd_rst` pulse during DATA.
  - Response: all outputs 0 in the same cycle (async); after release, the FSM is in IDLE with `busy`=0.

Source files
------------

// File: rtl/wr_fifo_burst_reader.sv
// Read-side drain engine for the frame write FIFO: waits for a full burst of data,
// issues one address request, then streams the burst through a 2-entry skid buffer.
module wr_fifo_burst_reader #(
   parameter int c_DATA_WIDTH  = 32,
   parameter int c_LEVEL_WIDTH = 11,
   parameter int c_ADDR_WIDTH  = 28,
   parameter int c_BURST_LEN   = 16
) (
   input  logic                     rd_clk,
   input  logic                     rd_rst,
   input  logic                     enable,
   input  logic [c_ADDR_WIDTH-1:0]  cfg_base_addr,
   input  logic [c_ADDR_WIDTH-1:0]  cfg_frame_beats,
   output logic                     fifo_rd_en,
   input  logic [c_DATA_WIDTH-1:0]  fifo_rd_data,
   input  logic                     fifo_rd_empty,
   input  logic [c_LEVEL_WIDTH-1:0] fifo_rd_water_level,
   output logic [c_ADDR_WIDTH-1:0]  aw_addr,
   output logic [7:0]               aw_len,
   output logic                     aw_valid,
   input  logic                     aw_ready,
   output logic [c_DATA_WIDTH-1:0]  w_data,
   output logic                     w_valid,
   input  logic                     w_ready,
   output logic                     w_last,
   output logic                     busy,
   output logic                     frame_done
);

   localparam logic [c_ADDR_WIDTH-1:0]  c_BURST_BYTES = c_ADDR_WIDTH'(c_BURST_LEN * (c_DATA_WIDTH / 8));
   localparam logic [c_ADDR_WIDTH-1:0]  c_BURST_BEATS = c_ADDR_WIDTH'(c_BURST_LEN);
   localparam logic [c_LEVEL_WIDTH-1:0] c_LEVEL_MIN   = c_LEVEL_WIDTH'(c_BURST_LEN);
   localparam logic [7:0]               c_LAST_IDX    = 8'(c_BURST_LEN - 1);
   localparam logic [8:0]               c_READS       = 9'(c_BURST_LEN);

   typedef enum logic [1:0] {IDLE, WAIT_LEVEL, ADDR, DATA} state_t;

   state_t                    state, state_next;
   logic [c_ADDR_WIDTH-1:0]   addr;
   logic [c_ADDR_WIDTH-1:0]   remaining;
   logic [c_ADDR_WIDTH-1:0]   remaining_after;
   logic [8:0]                reads_left;
   logic [7:0]                beat_idx;
   logic                      inflight;
   logic [c_DATA_WIDTH-1:0]   skid_mem [0:1];
   logic                      skid_wr_ptr;
   logic                      skid_rd_ptr;
   logic [1:0]                skid_count;
   logic [2:0]                skid_occ;
   logic                      pop;
   logic                      last_beat;
   logic                      level_ok;
   logic                      frame_end;

   assign aw_len          = c_LAST_IDX;
   assign aw_addr         = addr;
   assign aw_valid        = (state == ADDR);
   assign busy            = (state != IDLE);
   assign w_valid         = (state == DATA) && (skid_count != 2'd0);
   assign w_data          = skid_mem[skid_rd_ptr];
   assign w_last          = w_valid && (beat_idx == c_LAST_IDX);
   assign pop             = w_valid & w_ready;
   assign last_beat       = pop & w_last;
   assign level_ok        = (fifo_rd_water_level >= c_LEVEL_MIN);
   assign remaining_after = remaining - c_BURST_BEATS;
   assign frame_end       = last_beat && (remaining_after == '0);

   // Counting the read already in flight keeps the two skid entries from ever overflowing.
   assign skid_occ   = {1'b0, skid_count} + {2'b00, inflight} - {2'b00, pop};
   assign fifo_rd_en = ((state == ADDR) || (state == DATA)) && (reads_left != 9'd0) &&
                       !fifo_rd_empty && (skid_occ < 3'd2);

   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:       if (enable)    state_next = WAIT_LEVEL;
         WAIT_LEVEL: if (level_ok)  state_next = ADDR;
         ADDR:       if (aw_ready)  state_next = DATA;
         DATA:       if (last_beat) state_next = enable ? WAIT_LEVEL : IDLE;
         default:                   state_next = IDLE;
      endcase
   end

   // Frame bookkeeping: a finished frame with enable still high re-latches the config.
   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
         addr       <= '0;
         remaining  <= '0;
         reads_left <= '0;
         beat_idx   <= '0;
         inflight   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         inflight   <= fifo_rd_en;
         frame_done <= frame_end;
         if (state == IDLE && enable) begin
            addr      <= cfg_base_addr;
            remaining <= cfg_frame_beats;
         end
         if (state == WAIT_LEVEL && level_ok) begin
            reads_left <= c_READS;
            beat_idx   <= '0;
         end else if (fifo_rd_en) begin
            reads_left <= reads_left - 9'd1;
         end
         if (pop) beat_idx <= beat_idx + 8'd1;
         if (last_beat) begin
            if (frame_end && enable) begin
               addr      <= cfg_base_addr;
               remaining <= cfg_frame_beats;
            end else begin
               addr      <= addr + c_BURST_BYTES;
               remaining <= remaining_after;
            end
         end
      end
   end

   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
         skid_mem[0] <= '0;
         skid_mem[1] <= '0;
         skid_wr_ptr <= 1'b0;
         skid_rd_ptr <= 1'b0;
         skid_count  <= 2'd0;
      end else begin
         if (inflight) begin
            skid_mem[skid_wr_ptr] <= fifo_rd_data;
            skid_wr_ptr           <= ~skid_wr_ptr;
         end
         if (pop) skid_rd_ptr <= ~skid_rd_ptr;
         skid_count <= skid_occ[1:0];
      end
   end

endmodule
